sm_icache: RTL and testbench

Direct-mapped, read-only instruction cache that sits between the core's instruction fetch port (`imAddr`/`imData`) and a slower instruction memory with a req/ack handshake. On a hit it returns the instruction combinationally in the same cycle. On a miss it raises `cpuHold`, fetches the word from memory, fills the line and then serves the hit. The core treats `cpuHold` as a stall: PC and register-file writes are frozen while it is high.

---
 rtl/sm_icache.sv | 119 +++++++++++
 tb/tb_sm_icache.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_icache.sv
// Direct-mapped, read-only instruction cache with one-word lines.
// Hits are served combinationally; misses stall the core while a single line is fetched over req/ack.
module sm_icache #(
  parameter int INDEX_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      cpuAddr,
  output logic [31:0]      cpuData,
  output logic             cpuHold,
  input  logic             flush,
  output logic             memReq,
  output logic [31:0]      memAddr,
  input  logic             memAck,
  input  logic [31:0]      memData,
  output logic [CNT_W-1:0] hitCount,
  output logic [CNT_W-1:0] missCount
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 32 - INDEX_W;

  typedef enum logic {LOOKUP, FILL} state_e;

  state_e             state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [TAG_W-1:0]   tag_d  [LINES];
  logic [31:0]        data_q [LINES];
  logic [31:0]        data_d [LINES];
  logic               mem_req_q, mem_req_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]   hit_count_q, hit_count_d;
  logic [CNT_W-1:0]   miss_count_q, miss_count_d;

  logic [INDEX_W-1:0] cpu_idx;
  logic [INDEX_W-1:0] fill_idx;
  logic [TAG_W-1:0]   cpu_tag;
  logic               hit;
  logic               fill_done;

  assign cpu_idx   = cpuAddr[INDEX_W-1:0];
  assign cpu_tag   = cpuAddr[31:INDEX_W];
  assign fill_idx  = mem_addr_q[INDEX_W-1:0];
  assign hit       = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag) &&
                     (state_q == LOOKUP) && !rst;
  assign fill_done = (state_q == FILL) && memAck && !rst;

  assign cpuData   = data_q[cpu_idx];
  assign cpuHold   = !hit;
  assign memReq    = mem_req_q;
  assign memAddr   = mem_addr_q;
  assign hitCount  = hit_count_q;
  assign missCount = miss_count_q;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    miss_count_d = miss_count_q;
    hit_count_d  = hit_count_q + CNT_W'(hit);

    case (state_q)
      LOOKUP: begin
        if (!hit && !flush) begin
          state_d      = FILL;
          mem_req_d    = 1'b1;
          mem_addr_d   = cpuAddr;
          miss_count_d = miss_count_q + CNT_W'(1);
        end
      end
      FILL: begin
        if (memAck) begin
          state_d            = LOOKUP;
          mem_req_d          = 1'b0;
          valid_d[fill_idx]  = 1'b1;
        end
      end
      default: state_d = LOOKUP;
    endcase

    if (fill_done) begin
      data_d[fill_idx] = memData;
      tag_d[fill_idx]  = mem_addr_q[31:INDEX_W];
    end

    // Flush is applied last so it overrides the valid bit set by a completing fill.
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOOKUP;
      valid_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Line payload needs no reset: the valid bits alone decide whether it is used.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

endmodule

// File: tb/tb_sm_icache.sv
// Directed bench for sm_icache: a memory responder, a fetch driver and a
// hit monitor that checks every served instruction against an expected queue.
module tb_sm_icache;

  logic        clk;
  logic        rst;
  logic [31:0] cpuAddr;
  logic [31:0] cpuData;
  logic        cpuHold;
  logic        flush;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [31:0] memData;
  logic [15:0] hitCount;
  logic [15:0] missCount;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];

  int          ack_delay   = 0;
  bit          manual_mode = 0;
  logic        manual_ack  = 0;
  logic [31:0] manual_data = 0;
  int          wait_cnt    = 0;
  int          last_req_len = 0;
  logic [31:0] req_addr;

  sm_icache #(.INDEX_W(3), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpuAddr   (cpuAddr),
    .cpuData   (cpuData),
    .cpuHold   (cpuHold),
    .flush     (flush),
    .memReq    (memReq),
    .memAddr   (memAddr),
    .memAck    (memAck),
    .memData   (memData),
    .hitCount  (hitCount),
    .missCount (missCount)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h10:  return 32'h24020005;
      32'h08:  return 32'h11110008;
      32'h03:  return 32'h33330003;
      32'h01:  return 32'hAAAA0001;
      32'h02:  return 32'hBBBB0002;
      32'h05:  return 32'h55550005;
      32'h06:  return 32'h66660006;
      32'h20:  return 32'hCCCC0020;
      32'h21:  return 32'hDDDD0021;
      default: return 32'hDEAD0000;
    endcase
  endfunction

  // Memory responder: acks ack_delay cycles after memReq is first seen.
  initial begin
    memAck  = 1'b0;
    memData = '0;
    forever begin
      @(posedge clk);
      #1;
      if (manual_mode) begin
        memAck   = manual_ack;
        memData  = manual_data;
        wait_cnt = 0;
      end else if (memReq === 1'b1 && !rst) begin
        if (wait_cnt == 0) req_addr = memAddr;
        else chk("mem_addr_stable", memAddr, req_addr);
        if (wait_cnt == ack_delay) begin
          memAck       = 1'b1;
          memData      = mem_word(memAddr);
          last_req_len = wait_cnt + 1;
          wait_cnt     = 0;
        end else begin
          memAck = 1'b0;
          wait_cnt++;
        end
      end else begin
        memAck   = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Hit monitor: every cycle the cache serves data it must match the queue head.
  always @(negedge clk) begin
    if (rst === 1'b0 && cpuHold === 1'b0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_hit: got addr=%0h data=%0h want=no hit", cpuAddr, cpuData);
      end else begin
        chk("hit_addr_data", {cpuAddr, cpuData}, exp_q.pop_front());
      end
    end
  end

  // Present addr from a drive point; expect exp_hold stall cycles then n_hits hit cycles.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                       input int exp_hold, input int n_hits);
    int hold_cnt = 0;
    bit to = 0;
    for (int i = 0; i < n_hits; i++) exp_q.push_back({addr, data});
    cpuAddr = addr;
    @(negedge clk);
    while (cpuHold !== 1'b0 && !to) begin
      hold_cnt++;
      if (hold_cnt > 60) to = 1;
      else @(negedge clk);
    end
    if (to) begin
      total++;
      bad++;
      $display("FAIL fetch_timeout: addr=%0h got=no hit want=hit", addr);
    end
    chk("hold_cycles", hold_cnt, exp_hold);
    repeat (n_hits - 1) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    flush   = 1'b0;
    cpuAddr = 32'h10;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hold", cpuHold, 1'b1);
    chk("rst_mem_req", memReq, 1'b0);
    chk("rst_mem_addr", memAddr, 32'h0);
    chk("rst_hit_count", hitCount, 16'd0);
    chk("rst_miss_count", missCount, 16'd0);

    // Cold miss with ack one cycle after memReq
    for (int i = 0; i < 3; i++) exp_q.push_back({32'h10, 32'h24020005});
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("cold_hold0", cpuHold, 1'b1);
    chk("cold_req0", memReq, 1'b0);
    @(negedge clk);
    chk("cold_req1", memReq, 1'b1);
    chk("cold_addr1", memAddr, 32'h10);
    chk("cold_miss_count", missCount, 16'd1);
    chk("cold_hold1", cpuHold, 1'b1);
    @(negedge clk);
    chk("cold_hold2", cpuHold, 1'b0);
    chk("cold_hit_count0", hitCount, 16'd0);
    repeat (2) @(negedge clk);
    chk("cold_hit_count2", hitCount, 16'd2);
    tick();

    // Slow memory: ack 5 cycles late
    ack_delay = 5;
    fetch(32'h03, 32'h33330003, 7, 1);
    chk("slow_req_len", last_req_len, 6);
    chk("slow_miss_count", missCount, 16'd2);
    chk("slow_hit_count", hitCount, 16'd4);

    // Conflict on index 0
    ack_delay = 0;
    fetch(32'h08, 32'h11110008, 2, 1);
    fetch(32'h10, 32'h24020005, 2, 1);
    fetch(32'h08, 32'h11110008, 2, 1);
    chk("conflict_miss_count", missCount, 16'd5);
    chk("conflict_hit_count", hitCount, 16'd7);

    // Flush
    fetch(32'h01, 32'hAAAA0001, 2, 1);
    fetch(32'h02, 32'hBBBB0002, 2, 1);
    fetch(32'h01, 32'hAAAA0001, 0, 1);
    flush = 1'b1;
    fetch(32'h01, 32'hAAAA0001, 0, 1);
    flush = 1'b0;
    fetch(32'h01, 32'hAAAA0001, 2, 1);
    chk("flush_miss_count", missCount, 16'd8);
    flush   = 1'b1;
    cpuAddr = 32'h02;
    @(negedge clk);
    chk("flush_suppress_hold", cpuHold, 1'b1);
    tick();
    flush = 1'b0;
    fetch(32'h02, 32'hBBBB0002, 2, 1);
    chk("flush_suppress_miss_count", missCount, 16'd9);
    chk("flush_hit_count", hitCount, 16'd13);

    // Flush in the ack cycle of a fill
    cpuAddr = 32'h05;
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ack_coincide", memAck, 1'b1);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_ack_still_miss", cpuHold, 1'b1);
    tick();
    fetch(32'h05, 32'h55550005, 1, 1);
    chk("flush_ack_miss_count", missCount, 16'd11);
    chk("flush_ack_hit_count", hitCount, 16'd14);

    // Reset mid-fill, then a late ack
    ack_delay = 100;
    cpuAddr   = 32'h06;
    tick();
    @(negedge clk);
    chk("rstfill_req", memReq, 1'b1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rstfill_hold_in_rst", cpuHold, 1'b1);
    manual_mode = 1;
    manual_ack  = 1'b1;
    manual_data = 32'h0BADF00D;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstfill_req_dropped", memReq, 1'b0);
    chk("rstfill_hold", cpuHold, 1'b1);
    chk("rstfill_hit_count", hitCount, 16'd0);
    chk("rstfill_miss_count", missCount, 16'd0);
    manual_mode = 0;
    manual_ack  = 1'b0;
    ack_delay   = 0;
    tick();
    fetch(32'h06, 32'h66660006, 1, 1);
    chk("rstfill_refill_miss_count", missCount, 16'd1);
    chk("rstfill_refill_hit_count", hitCount, 16'd1);

    // Address change during fill
    ack_delay = 2;
    cpuAddr   = 32'h20;
    tick();
    cpuAddr = 32'h21;
    @(negedge clk);
    chk("addrchg_mem_addr", memAddr, 32'h20);
    chk("addrchg_hold", cpuHold, 1'b1);
    tick();
    fetch(32'h21, 32'hDDDD0021, 6, 1);
    fetch(32'h20, 32'hCCCC0020, 0, 1);
    fetch(32'h21, 32'hDDDD0021, 0, 1);
    chk("addrchg_miss_count", missCount, 16'd3);
    chk("addrchg_hit_count", hitCount, 16'd4);

    chk("exp_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
